// File: rtl/writeback_regfile_pkg.sv
// Shared constants and types for the writeback / register file slice.
//   DATA_W   : datapath and register width
//   ADDR_W   : register index width
//   NREG     : number of architectural registers
//   REG_ZERO : index of the hardwired-zero register
//   wb_sel_e : source of a committed register value (ALU or data memory)
package writeback_regfile_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned NREG   = 8;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/writeback_regfile_core.sv
// Register storage with two combinational read ports and two write ports.
// Write port B wins when both ports target the same index. Index 0 is never
// written, so it always reads back zero.
//   clk, RST                    : clock, synchronous active-high reset
//   rd_a_addr_i / rd_a_data_o   : read port A
//   rd_b_addr_i / rd_b_data_o   : read port B
//   wr_a_en_i/_addr_i/_data_i   : write port A
//   wr_b_en_i/_addr_i/_data_i   : write port B (priority)
module regfile_core #(
    parameter int unsigned DataW = 8,
    parameter int unsigned NReg  = 8,
    parameter int unsigned AddrW = 3
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [AddrW-1:0] rd_a_addr_i,
    output logic [DataW-1:0] rd_a_data_o,
    input  logic [AddrW-1:0] rd_b_addr_i,
    output logic [DataW-1:0] rd_b_data_o,
    input  logic             wr_a_en_i,
    input  logic [AddrW-1:0] wr_a_addr_i,
    input  logic [DataW-1:0] wr_a_data_i,
    input  logic             wr_b_en_i,
    input  logic [AddrW-1:0] wr_b_addr_i,
    input  logic [DataW-1:0] wr_b_data_i
);

    logic [DataW-1:0] regs_q [NReg];
    logic [DataW-1:0] regs_d [NReg];

    always_comb begin
        for (int i = 0; i < int'(NReg); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_a_en_i && (wr_a_addr_i != '0)) begin
            regs_d[wr_a_addr_i] = wr_a_data_i;
        end
        // Applied second so port B overrides port A on the same index.
        if (wr_b_en_i && (wr_b_addr_i != '0)) begin
            regs_d[wr_b_addr_i] = wr_b_data_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NReg); i++) begin
            regs_q[i] <= RST ? '0 : regs_d[i];
        end
    end

    assign rd_a_data_o = regs_q[rd_a_addr_i];
    assign rd_b_data_o = regs_q[rd_b_addr_i];

endmodule

// File: rtl/writeback_regfile.sv
// Register file plus writeback stage. Tracks a single pending load whose data
// arrives from data memory one cycle after issue, bypasses that data to the
// read ports while pending, and arbitrates ALU vs. load commits (ALU wins).
//   clk, RST                    : clock, synchronous active-high reset
//   rs_addr, rt_addr            : read indices
//   rd_addr, RegWrite, MemToReg : destination control of current instruction
//   alu_result, memReadData     : candidate write values
//   regReadDataOne/Two          : combinational read operands
//   wb_en, wb_addr, wb_data     : commit happening at the coming clk edge
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = writeback_regfile_pkg::DATA_W,
    parameter int unsigned NREG   = writeback_regfile_pkg::NREG,
    parameter int unsigned ADDR_W = writeback_regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] memReadData,
    output logic [DATA_W-1:0] regReadDataOne,
    output logic [DATA_W-1:0] regReadDataTwo,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              alu_wr, load_issue;
    logic [DATA_W-1:0] core_rs_data, core_rt_data;
    wb_sel_e           wb_sel;

    assign alu_wr     = RegWrite && !MemToReg && (rd_addr != ADDR_W'(REG_ZERO));
    assign load_issue = RegWrite &&  MemToReg && (rd_addr != ADDR_W'(REG_ZERO));

    always_comb begin
        pend_valid_d = load_issue;
        pend_addr_d  = pend_addr_q;
        if (load_issue) begin
            pend_addr_d = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    // Load completion on port A, ALU on port B so the younger ALU write wins.
    regfile_core #(
        .DataW (DATA_W),
        .NReg  (NREG),
        .AddrW (ADDR_W)
    ) u_core (
        .clk         (clk),
        .RST         (RST),
        .rd_a_addr_i (rs_addr),
        .rd_a_data_o (core_rs_data),
        .rd_b_addr_i (rt_addr),
        .rd_b_data_o (core_rt_data),
        .wr_a_en_i   (pend_valid_q),
        .wr_a_addr_i (pend_addr_q),
        .wr_a_data_i (memReadData),
        .wr_b_en_i   (alu_wr),
        .wr_b_addr_i (rd_addr),
        .wr_b_data_i (alu_result)
    );

    always_comb begin
        regReadDataOne = core_rs_data;
        regReadDataTwo = core_rt_data;
        if (rs_addr == ADDR_W'(REG_ZERO)) begin
            regReadDataOne = '0;
        end else if (pend_valid_q && (rs_addr == pend_addr_q)) begin
            regReadDataOne = memReadData;
        end
        if (rt_addr == ADDR_W'(REG_ZERO)) begin
            regReadDataTwo = '0;
        end else if (pend_valid_q && (rt_addr == pend_addr_q)) begin
            regReadDataTwo = memReadData;
        end
    end

    always_comb begin
        wb_sel  = alu_wr ? WB_ALU : WB_MEM;
        wb_en   = !RST && (alu_wr || pend_valid_q);
        wb_addr = '0;
        wb_data = '0;
        if (wb_en) begin
            if (wb_sel == WB_ALU) begin
                wb_addr = rd_addr;
                wb_data = alu_result;
            end else begin
                wb_addr = pend_addr_q;
                wb_data = memReadData;
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic       clk = 1'b0;
    logic       RST;
    logic [2:0] rs_addr, rt_addr, rd_addr;
    logic       RegWrite, MemToReg;
    logic [7:0] alu_result, memReadData;
    logic [7:0] regReadDataOne, regReadDataTwo;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    writeback_regfile dut (
        .clk            (clk),
        .RST            (RST),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rd_addr        (rd_addr),
        .RegWrite       (RegWrite),
        .MemToReg       (MemToReg),
        .alu_result     (alu_result),
        .memReadData    (memReadData),
        .regReadDataOne (regReadDataOne),
        .regReadDataTwo (regReadDataTwo),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data)
    );

    // Data memory contents used by the loads: mem[a] = a below 16, else 0xFF.
    function automatic logic [7:0] mem_val(input int a);
        return (a < 16) ? 8'(a) : 8'hFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        rd_addr     = 3'd0;
        alu_result  = 8'h00;
        memReadData = 8'hEE;
    endtask

    task automatic test_reset();
        RST = 1'b1; idle(); rs_addr = 0; rt_addr = 0;
        step();
        RegWrite = 1'b1; rd_addr = 3'd2; alu_result = 8'hAA;
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++; $display("FAIL rst_wb_en got=%b want=0", wb_en);
        end
        step();
        RST = 1'b0; idle();
        for (int i = 0; i < 8; i++) begin
            rs_addr = 3'(i);
            #1;
            total++;
            if (regReadDataOne !== 8'h00) begin
                bad++; $display("FAIL rst_read r%0d got=%h want=00", i, regReadDataOne);
            end
        end
        RegWrite = 1'b1; rd_addr = 3'd0; alu_result = 8'h55;
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++; $display("FAIL r0_write_wb_en got=%b want=0", wb_en);
        end
        step();
        idle(); rs_addr = 3'd0;
        #1;
        total++;
        if (regReadDataOne !== 8'h00) begin
            bad++; $display("FAIL r0_hardwired got=%h want=00", regReadDataOne);
        end
    endtask

    task automatic test_alu_write();
        RegWrite = 1'b1; rd_addr = 3'd2; alu_result = 8'h3C; rs_addr = 3'd2;
        #1;
        total++;
        if (regReadDataOne !== 8'h00) begin
            bad++; $display("FAIL alu_no_bypass got=%h want=00", regReadDataOne);
        end
        total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 3'd2, 8'h3C}) begin
            bad++; $display("FAIL alu_commit got=%b/%0d/%h want=1/2/3c", wb_en, wb_addr, wb_data);
        end
        step();
        idle();
        #1;
        total++;
        if (regReadDataOne !== 8'h3C) begin
            bad++; $display("FAIL alu_visible got=%h want=3c", regReadDataOne);
        end
        total++;
        if ({wb_en, wb_addr, wb_data} !== 12'h000) begin
            bad++; $display("FAIL idle_wb got=%b/%0d/%h want=0/0/00", wb_en, wb_addr, wb_data);
        end
    endtask

    // Issue a load of memory address a into register r; check the bypass
    // and commit in N+1 and the stored value in N+2.
    task automatic test_load(input logic [2:0] r, input int a);
        RegWrite = 1'b1; MemToReg = 1'b1; rd_addr = r; rs_addr = r;
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++; $display("FAIL load_issue_wb_en r%0d got=%b want=0", r, wb_en);
        end
        step();
        idle(); memReadData = mem_val(a);
        #1;
        total++;
        if (regReadDataOne !== mem_val(a)) begin
            bad++; $display("FAIL load_bypass r%0d got=%h want=%h", r, regReadDataOne, mem_val(a));
        end
        total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, r, mem_val(a)}) begin
            bad++; $display("FAIL load_commit got=%b/%0d/%h want=1/%0d/%h",
                            wb_en, wb_addr, wb_data, r, mem_val(a));
        end
        step();
        idle();
        #1;
        total++;
        if (regReadDataOne !== mem_val(a)) begin
            bad++; $display("FAIL load_stored r%0d got=%h want=%h", r, regReadDataOne, mem_val(a));
        end
    endtask

    task automatic test_collision(input logic [2:0] alu_rd, input int a);
        RegWrite = 1'b1; MemToReg = 1'b1; rd_addr = 3'd3;
        step();
        RegWrite = 1'b1; MemToReg = 1'b0; rd_addr = alu_rd; alu_result = 8'h77;
        memReadData = mem_val(a); rs_addr = 3'd3;
        #1;
        total++;
        if (regReadDataOne !== mem_val(a)) begin
            bad++; $display("FAIL coll_bypass got=%h want=%h", regReadDataOne, mem_val(a));
        end
        total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, alu_rd, 8'h77}) begin
            bad++; $display("FAIL coll_commit got=%b/%0d/%h want=1/%0d/77",
                            wb_en, wb_addr, wb_data, alu_rd);
        end
        step();
        idle(); rs_addr = 3'd3; rt_addr = alu_rd;
        #1;
        total++;
        if (regReadDataOne !== ((alu_rd == 3'd3) ? 8'h77 : mem_val(a))) begin
            bad++; $display("FAIL coll_r3 got=%h want=%h", regReadDataOne,
                            (alu_rd == 3'd3) ? 8'h77 : mem_val(a));
        end
        total++;
        if (regReadDataTwo !== 8'h77) begin
            bad++; $display("FAIL coll_alu_reg r%0d got=%h want=77", alu_rd, regReadDataTwo);
        end
    endtask

    task automatic test_back_to_back();
        RegWrite = 1'b1; MemToReg = 1'b1; rd_addr = 3'd1;
        step();
        rd_addr = 3'd2; memReadData = mem_val(5); rs_addr = 3'd1; rt_addr = 3'd2;
        #1;
        total++;
        if (regReadDataOne !== 8'h05) begin
            bad++; $display("FAIL b2b_bypass1 got=%h want=05", regReadDataOne);
        end
        total++;
        if (regReadDataTwo !== 8'h3C) begin
            bad++; $display("FAIL b2b_r2_old got=%h want=3c", regReadDataTwo);
        end
        total++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 3'd1, 8'h05}) begin
            bad++; $display("FAIL b2b_commit1 got=%b/%0d/%h want=1/1/05", wb_en, wb_addr, wb_data);
        end
        step();
        idle(); memReadData = mem_val(6);
        #1;
        total++;
        if (regReadDataTwo !== 8'h06) begin
            bad++; $display("FAIL b2b_bypass2 got=%h want=06", regReadDataTwo);
        end
        step();
        idle();
        #1;
        total++;
        if ({regReadDataOne, regReadDataTwo} !== 16'h0506) begin
            bad++; $display("FAIL b2b_stored got=%h/%h want=05/06", regReadDataOne, regReadDataTwo);
        end
    endtask

    task automatic test_reset_mid_load();
        RegWrite = 1'b1; MemToReg = 1'b1; rd_addr = 3'd7;
        step();
        idle(); RST = 1'b1; memReadData = 8'h07; rs_addr = 3'd7; rt_addr = 3'd2;
        #1;
        total++;
        if (wb_en !== 1'b0) begin
            bad++; $display("FAIL rstload_wb_en got=%b want=0", wb_en);
        end
        step();
        RST = 1'b0;
        #1;
        total++;
        if (regReadDataOne !== 8'h00) begin
            bad++; $display("FAIL rstload_no_bypass got=%h want=00", regReadDataOne);
        end
        total++;
        if (wb_en !== 1'b0) begin
            bad++; $display("FAIL rstload_no_commit got=%b want=0", wb_en);
        end
        total++;
        if (regReadDataTwo !== 8'h00) begin
            bad++; $display("FAIL rstload_r2_cleared got=%h want=00", regReadDataTwo);
        end
        step();
        #1;
        total++;
        if (regReadDataOne !== 8'h00) begin
            bad++; $display("FAIL rstload_r7 got=%h want=00", regReadDataOne);
        end
    endtask

    initial begin
        RST = 1'b1; rs_addr = 0; rt_addr = 0; idle();
        #1;
        test_reset();
        test_alu_write();
        test_load(3'd4, 3);
        test_load(3'd5, 17);
        test_collision(3'd3, 9);
        test_collision(3'd6, 10);
        test_back_to_back();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Register file plus writeback stage of the 8-bit CPU.
- Sits directly downstream of the data memory and consumes its registered memReadData. It also consumes the ALU result, and supplies both register read operands: regReadDataTwo feeds the data memory store port, and the ALU takes the rest.
- Owns load-data timing. Data memory returns read data one clock after MemRead, so this block holds load destinations pending for one cycle and bypasses the arriving load data to readers.

Parameters:
- DATA_W, 8, register and datapath width.
- NREG, 8, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 3, register index width; equals log2(NREG).

Ports:
- clk  in  1  clock
- RST  in  1  reset, synchronous, active-high; clock clk
- rs_addr  in  ADDR_W  read port one index
- rt_addr  in  ADDR_W  read port two index
- rd_addr  in  ADDR_W  destination index of the instruction in the current cycle
- RegWrite  in  1  current instruction writes rd_addr
- MemToReg  in  1  destination value comes from data memory (load), not the ALU
- alu_result  in  DATA_W  ALU result for the current instruction
- memReadData  in  DATA_W  data memory output; valid the cycle after the load issued
- regReadDataOne  out  DATA_W  operand for rs_addr (combinational)
- regReadDataTwo  out  DATA_W  operand for rt_addr (combinational; also store data)
- wb_en  out  1  a register commit happens at the coming clk edge
- wb_addr  out  ADDR_W  index being committed
- wb_data  out  DATA_W  value being committed

Behaviour:
- State: regs[NREG], pend_valid (1 bit), pend_addr (ADDR_W).
- Reset (RST high at posedge):
  - all regs become 0; pend_valid becomes 0.
  - RST overrides any write in that cycle.
  - A load pending at reset is dropped, and its data is never written.
- ALU write: RegWrite=1, MemToReg=0, rd≠0 → regs[rd] <= alu_result at the end of the same cycle. Latency is 1 edge.
- Load issue: RegWrite=1, MemToReg=1 → pend_valid <= 1, pend_addr <= rd. No write in this cycle.
  - If rd=0, pend_valid stays 0.
- Load complete: if pend_valid=1 in cycle N+1 → regs[pend_addr] <= memReadData at the end of N+1. pend_valid then clears unless a new load issues in N+1.
- Back-to-back loads: a load completes while the next load issues; both happen in the same cycle.
- Dual commit: a load completion and an ALU write may land in the same cycle.
  - Different indices: both commit.
  - Same index: the ALU write (younger instruction) wins.
- Commit observation (wb_en/wb_addr/wb_data):
  - Reports the ALU write if one is present, otherwise the load completion.
  - wb_en is 0 during RST and when nothing commits.
  - wb_addr and wb_data are don't-care (drive 0) when wb_en=0.
- Read ports are combinational, evaluated in this priority order:
  1. index 0 → 0;
  2. pend_valid and index==pend_addr → memReadData (load bypass);
  3. otherwise regs[index].
- There is no ALU bypass. ALU values are visible from the next cycle, through the registered write.
- Writes to register 0 are ignored in every path.
- Arithmetic: none; all values pass through at DATA_W bits unmodified.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W constants;
  - REG_ZERO = 0 constant;
  - a wb_sel enum (WB_ALU, WB_MEM) reused by the control decoder.
- One sub-module is natural: regfile_core. It contains the storage array, two combinational read ports and two write ports with port-B priority.
- writeback_regfile wraps regfile_core and adds pend tracking, the bypass mux and commit arbitration.

Test Plan:
- Reset and read-zero: assert RST 1 cycle → rs=0..7 all read 0x00, wb_en=0. Write rd=0 with alu 0x55 → r0 still reads 0x00.
- ALU write timing: write rd=2 with alu 0x3C.
  - In the same cycle, rs=2 still reads the old value 0x00.
  - In the next cycle it reads 0x3C, with wb_en=1, wb_addr=2, wb_data=0x3C during the write cycle.
- Load through data memory after its reset: load addr 3 into r4 → in cycle N+1, rs=4 bypasses memReadData=0x03. In N+2, regs[4]=0x03.
- Second load: load addr 17 into r5 → r5=0xFF.
- Load/ALU collision: load into r3 in cycle N, then ALU write r3=0x77 in N+1 → r3=0x77 and wb_addr=3, wb_data=0x77. Repeat with ALU rd=6 → r3 holds the memory data and r6=0x77, both committed.
- Back-to-back loads to r1 then r2 (mem addr 5, 6) → r1=0x05, r2=0x06. In cycle N+1, rs=1 bypasses 0x05 while r2 is pending.
- Reset mid-load: issue load into r7, assert RST in N+1 → r7=0x00 and pend_valid=0. No commit follows, so wb_en stays 0.
